// File: rtl/vga_timing_pkg.sv
// VGA 640x480 timing constants shared by the sprite and display blocks,
// plus the bundle of registered per-pixel scanner outputs.
package vga_timing_pkg;

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_FRONT      = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BACK       = 10'd48;
  localparam logic [9:0] H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam logic [9:0] H_MAX        = H_TOTAL - 10'd1;
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_FRONT      = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BACK       = 10'd33;
  localparam logic [9:0] V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] V_MAX        = V_TOTAL - 10'd1;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       in_pix;
    logic [9:0] hc;
    logic [9:0] vc;
  } scan_out_t;

  // Syncs are active-low, so idle means both high and nothing visible.
  localparam scan_out_t SCAN_IDLE = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0,
                                      in_pix: 1'b0, hc: 10'd0, vc: 10'd0};

endpackage

// File: rtl/pix_tick_gen.sv
// Free-running CLK divider: tick_o is high for one CLK out of every CLK_DIV.
module pix_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;

  assign tick_o = (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q + 1'b1;
    if (tick_o) div_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) div_q <= '0;
    else       div_q <= div_d;
  end

endmodule

// File: rtl/vga_sprite_scanner.sv
// VGA 640x480 raster scanner with a scaled sprite window and sprite-local coordinates.
// Define FRAME_LATCH_EN to sample spr_x/spr_y once per frame instead of using them live.
module vga_sprite_scanner
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int SPR_W      = 30,
  parameter int SPR_H      = 7,
  parameter int SCALE_LOG2 = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] spr_x,
  input  logic [9:0] spr_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       is_in_pixel,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       pix_tick
);

  localparam logic [10:0] WIN_W = 11'(SPR_W << SCALE_LOG2);
  localparam logic [10:0] WIN_H = 11'(SPR_H << SCALE_LOG2);

  logic        tick;
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic        h_wrap, v_wrap;
  logic [9:0]  win_x, win_y;
  logic [10:0] x_end, y_end;
  logic        in_x, in_y, vis, in_win;
  scan_out_t   out_q, out_d;
  logic        pix_tick_q;

  pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk_i (CLK),
    .rst_i (RST),
    .tick_o(tick)
  );

  assign h_wrap = (h_q == H_MAX);
  assign v_wrap = (v_q == V_MAX);

  // h_q/v_q name the pixel presented on the next tick, so the first tick shows (0,0).
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      h_d = h_wrap ? 10'd0 : h_q + 10'd1;
      if (h_wrap) v_d = v_wrap ? 10'd0 : v_q + 10'd1;
    end
  end

`ifdef FRAME_LATCH_EN
  logic [9:0] sx_q, sy_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sx_q <= '0;
      sy_q <= '0;
    end else if (tick && h_wrap && v_wrap) begin
      sx_q <= spr_x;
      sy_q <= spr_y;
    end
  end

  assign win_x = sx_q;
  assign win_y = sy_q;
`else
  assign win_x = spr_x;
  assign win_y = spr_y;
`endif

  // 11-bit upper bounds: a sprite near 1023 must not wrap back onto the screen.
  assign x_end  = {1'b0, win_x} + WIN_W;
  assign y_end  = {1'b0, win_y} + WIN_H;
  assign in_x   = (h_q >= win_x) && ({1'b0, h_q} < x_end);
  assign in_y   = (v_q >= win_y) && ({1'b0, v_q} < y_end);
  assign vis    = (h_q < H_VISIBLE) && (v_q < V_VISIBLE);
  assign in_win = vis && in_x && in_y;

  always_comb begin
    out_d          = SCAN_IDLE;
    out_d.hsync    = ~((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
    out_d.vsync    = ~((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
    out_d.video_on = vis;
    out_d.in_pix   = in_win;
    if (in_win) begin
      out_d.hc = h_q - win_x;
      out_d.vc = v_q - win_y;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      h_q        <= '0;
      v_q        <= '0;
      out_q      <= SCAN_IDLE;
      pix_tick_q <= 1'b0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      pix_tick_q <= tick;
      if (tick) out_q <= out_d;
    end
  end

  assign hsync       = out_q.hsync;
  assign vsync       = out_q.vsync;
  assign video_on    = out_q.video_on;
  assign is_in_pixel = out_q.in_pix;
  assign hc          = out_q.hc;
  assign vc          = out_q.vc;
  assign pix_tick    = pix_tick_q;

endmodule

// File: tb/tb_vga_sprite_scanner.sv
// Bench for vga_sprite_scanner: reset behaviour, sync timing, window placement,
// clipping, counter wrap and per-frame sprite position update (FRAME_LATCH_EN aware).
module tb_vga_sprite_scanner;

`ifdef FRAME_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif
  localparam int CLK_DIV = 4;
  localparam int WIN_W   = 120;
  localparam int WIN_H   = 28;

  // ---------------- clock / reset / DUT ----------------
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [9:0] spr_x = 10'd0;
  logic [9:0] spr_y = 10'd0;
  logic       hsync, vsync, video_on, is_in_pixel, pix_tick;
  logic [9:0] hc, vc;
  longint     cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  vga_sprite_scanner #(.CLK_DIV(CLK_DIV), .SPR_W(30), .SPR_H(7), .SCALE_LOG2(2)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .is_in_pixel(is_in_pixel),
    .hc         (hc),
    .vc         (vc),
    .pix_tick   (pix_tick)
  );

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q[$];

  int mh, mv, tick_idx, sh_x, sh_y;
  logic prev_hs, prev_vs, prev_vid;
  int win_cnt, win_err, sync_err;
  logic [15:0] f_h, f_v, f_hc, f_vc, l_h, l_v, l_hc, l_vc;
  bit hs_fall_valid, vs_fall_valid, vs_per_valid;
  int hs_fall_tick, vs_fall_tick, hs_len_last, hs_per_last, hs_clk_last, vs_len_last, vs_per_last;
  longint hs_fall_cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic finish_tb();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * CLK_DIV && !ok; i++) begin
      @(negedge CLK);
      if (pix_tick === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; tick_idx = 0; sh_x = 0; sh_y = 0;
    prev_hs = 1'b1; prev_vs = 1'b1; prev_vid = 1'b0;
    hs_fall_valid = 0; vs_fall_valid = 0; vs_per_valid = 0;
    hs_len_last = -1; hs_per_last = -1; hs_clk_last = -1; vs_len_last = -1; vs_per_last = -1;
  endtask

  // Expected window statistics for one frame; rows below sw use xa, the rest xb.
  task automatic start_frame(input int xa, input int xb, input int y, input int sw);
    int cnt, xr, hi, rl;
    cnt = 0;
    for (int r = y; r < y + WIN_H && r < 480; r++) begin
      xr = (r < sw) ? xa : xb;
      hi = (xr + WIN_W < 640) ? xr + WIN_W : 640;
      if (hi > xr) cnt += hi - xr;
    end
    exp_q.push_back(16'(cnt));
    if (cnt == 0) begin
      repeat (8) exp_q.push_back(16'hFFFF);
    end else begin
      xr = (y < sw) ? xa : xb;
      exp_q.push_back(16'(xr)); exp_q.push_back(16'(y));
      exp_q.push_back(16'd0);   exp_q.push_back(16'd0);
      rl = (y + WIN_H < 480) ? y + WIN_H - 1 : 479;
      xr = (rl < sw) ? xa : xb;
      hi = (xr + WIN_W < 640) ? xr + WIN_W - 1 : 639;
      exp_q.push_back(16'(hi));      exp_q.push_back(16'(rl));
      exp_q.push_back(16'(hi - xr)); exp_q.push_back(16'(rl - y));
    end
    win_cnt = 0; win_err = 0; sync_err = 0;
    f_h = 16'hFFFF; f_v = 16'hFFFF; f_hc = 16'hFFFF; f_vc = 16'hFFFF;
    l_h = 16'hFFFF; l_v = 16'hFFFF; l_hc = 16'hFFFF; l_vc = 16'hFFFF;
  endtask

  task automatic start_plain();
    if (LATCH) start_frame(sh_x, sh_x, sh_y, 0);
    else       start_frame(int'(spr_x), int'(spr_x), int'(spr_y), 0);
  endtask

  function automatic string stat_name(input int i);
    case (i)
      0: return "win_count";  1: return "first_h";  2: return "first_v";
      3: return "first_hc";   4: return "first_vc"; 5: return "last_h";
      6: return "last_v";     7: return "last_hc";  default: return "last_vc";
    endcase
  endfunction

  task automatic end_frame(input string name);
    logic [15:0] got [9];
    got[0] = 16'(win_cnt); got[1] = f_h; got[2] = f_v; got[3] = f_hc; got[4] = f_vc;
    got[5] = l_h; got[6] = l_v; got[7] = l_hc; got[8] = l_vc;
    check_eq({name, "_sb_depth"}, exp_q.size(), 9);
    for (int i = 0; i < 9; i++)
      if (exp_q.size() > 0) check_eq({name, "_", stat_name(i)}, got[i], exp_q.pop_front());
    check_eq({name, "_window_model_err"}, win_err, 0);
    check_eq({name, "_sync_model_err"}, sync_err, 0);
    check_eq({name, "_hsync_low_ticks"}, hs_len_last, 96);
    check_eq({name, "_hsync_period_ticks"}, hs_per_last, 800);
    check_eq({name, "_hsync_period_clks"}, hs_clk_last, 3200);
    check_eq({name, "_vsync_low_ticks"}, vs_len_last, 1600);
    if (vs_per_valid) check_eq({name, "_vsync_period_ticks"}, vs_per_last, 525 * 800);
    exp_q.delete();
  endtask

  // Monitor for one pix_tick: compare against the raster model, gather statistics, advance.
  task automatic sample_tick();
    int ex, ey;
    logic e_hs, e_vs, e_vid, e_in;
    ex = LATCH ? sh_x : int'(spr_x);
    ey = LATCH ? sh_y : int'(spr_y);
    e_vid = (mh < 640) && (mv < 480);
    e_hs  = !((mh >= 656) && (mh < 752));
    e_vs  = !((mv >= 490) && (mv < 492));
    e_in  = e_vid && (mh >= ex) && (mh < ex + WIN_W) && (mv >= ey) && (mv < ey + WIN_H);
    if (hsync !== e_hs || vsync !== e_vs || video_on !== e_vid) sync_err++;
    if (is_in_pixel !== e_in) win_err++;
    else if (e_in && (int'(hc) != mh - ex || int'(vc) != mv - ey)) win_err++;
    else if (!e_in && (hc !== 10'd0 || vc !== 10'd0)) win_err++;
    if (is_in_pixel === 1'b1) begin
      win_cnt++;
      if (f_h == 16'hFFFF) begin
        f_h = 16'(mh); f_v = 16'(mv); f_hc = {6'd0, hc}; f_vc = {6'd0, vc};
      end
      l_h = 16'(mh); l_v = 16'(mv); l_hc = {6'd0, hc}; l_vc = {6'd0, vc};
    end
    if (mh == 0 && mv == 0 && tick_idx > 0)
      check_eq("wrap_video_on_rise", {prev_vid, video_on}, 2'b01);
    if (prev_hs === 1'b1 && hsync === 1'b0) begin
      if (hs_fall_valid) begin
        hs_per_last = tick_idx - hs_fall_tick;
        hs_clk_last = int'(cyc - hs_fall_cyc);
        if (hs_per_last != 800 || hs_clk_last != 3200) sync_err++;
      end
      hs_fall_valid = 1; hs_fall_tick = tick_idx; hs_fall_cyc = cyc;
    end
    if (prev_hs === 1'b0 && hsync === 1'b1) begin
      hs_len_last = tick_idx - hs_fall_tick;
      if (hs_len_last != 96) sync_err++;
    end
    if (prev_vs === 1'b1 && vsync === 1'b0) begin
      if (vs_fall_valid) begin
        vs_per_last = tick_idx - vs_fall_tick;
        vs_per_valid = 1;
        if (vs_per_last != 525 * 800) sync_err++;
      end
      vs_fall_valid = 1; vs_fall_tick = tick_idx;
    end
    if (prev_vs === 1'b0 && vsync === 1'b1) begin
      vs_len_last = tick_idx - vs_fall_tick;
      if (vs_len_last != 1600) sync_err++;
    end
    prev_hs = hsync; prev_vs = vsync; prev_vid = video_on;
    if (mh == 799 && mv == 524) begin
      sh_x = int'(spr_x); sh_y = int'(spr_y);
    end
    tick_idx++;
    if (mh == 799) begin
      mh = 0;
      mv = (mv == 524) ? 0 : mv + 1;
    end else begin
      mh++;
    end
  endtask

  task automatic run_until(input int th, input int tv);
    bit ok;
    bit done;
    done = 1'b0;
    while (!done) begin
      wait_tick(ok);
      if (!ok) begin
        check_eq("pix_tick_timeout", 0, 1);
        finish_tb();
      end
      done = (mh == th) && (mv == tv);
      sample_tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok, seen;
    int n;
    spr_x = 10'd0; spr_y = 10'd0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    // Reset while inside the sprite window on line 1.
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      wait_tick(ok);
      if (ok && is_in_pixel === 1'b1 && vc >= 10'd1 && hc >= 10'd50) seen = 1;
    end
    check_eq("pre_reset_in_window", is_in_pixel, 1'b1);
    @(posedge CLK); #1 RST = 1'b1; #1;
    check_eq("rst_is_in_pixel", is_in_pixel, 1'b0);
    check_eq("rst_hc", hc, 10'd0);
    check_eq("rst_vc", vc, 10'd0);
    check_eq("rst_video_on", video_on, 1'b0);
    check_eq("rst_pix_tick", pix_tick, 1'b0);

    // Reset in the middle of an hsync pulse: the pulse must end at once.
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      wait_tick(ok);
      if (ok && hsync === 1'b0) seen = 1;
    end
    check_eq("pre_reset_hsync_low", hsync, 1'b0);
    @(posedge CLK); #1 RST = 1'b1; #1;
    check_eq("rst_hsync", hsync, 1'b1);
    check_eq("rst_vsync", vsync, 1'b1);
    repeat (3) @(negedge CLK);
    check_eq("rst_hold_pix_tick", pix_tick, 1'b0);

    // Frame 0: clipped sprite at the bottom-right corner.
    model_reset();
    spr_x = 10'd600; spr_y = 10'd470;
    start_plain();
    RST = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 4 * CLK_DIV) begin
      @(negedge CLK);
      n++;
      if (pix_tick === 1'b1) seen = 1;
    end
    check_eq("first_tick_clks", n, CLK_DIV);
    if (!seen) finish_tb();
    check_eq("first_tick_video_on", video_on, 1'b1);
    check_eq("first_tick_hsync", hsync, 1'b1);
    sample_tick();
    run_until(799, 524);
    end_frame("f0");

    // Frame 1: sprite entirely right of the visible area.
    spr_x = 10'd700; spr_y = 10'd50;
    start_plain();
    run_until(799, 524);
    end_frame("f1");

    // Frame 2: fully visible 120x28 window.
    spr_x = 10'd100; spr_y = 10'd50;
    start_plain();
    run_until(799, 524);
    end_frame("f2");

    // Frame 3: move the sprite mid-frame (row 60).
    if (LATCH) start_plain();
    else       start_frame(100, 200, 50, 60);
    run_until(799, 59);
    spr_x = 10'd200;
    run_until(799, 524);
    end_frame("f3");

    // Frame 4: the new position is in force from the top of the frame.
    start_plain();
    run_until(799, 79);
    end_frame("f4");

    finish_tb();
  end

endmodule
